mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised blocking arbiter granting NUM_REQ cache-side requesters (L1-I, L1-D, victim cache, …) exclusive access to one downstream line-granular memory port (L2 or RAM controller). It supports round-robin or fixed-priority selection and keeps one transaction in flight. A watchdog turns a lost downstream response into an error response. It sits between the L1/victim level and the next level of the memory hierarchy.

## Interface
Parameters:
- NUM_REQ, 3, number of requester channels (≥2)
- ADDR_W, 32, line-address width
- LINE_W, 256, data width of one cache line
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (index 0 highest)
- TIMEOUT, 1023, WAIT cycles before error response; 0 disables watchdog

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  request accepted (one-hot or zero)
- req_we  in  NUM_REQ  1 = line writeback, 0 = line fill
- req_addr  in  NUM_REQ×ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ×LINE_W  packed write lines
- resp_valid  out  NUM_REQ  one-cycle response pulse to the owner
- resp_err  out  1  response is a timeout error (qualified by resp_valid)
- resp_rdata  out  LINE_W  fill data, shared by all channels
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_we, mem_addr, mem_wdata  out  1/ADDR_W/LINE_W  captured request
- mem_resp_valid  in  1  downstream completion (reads and writes)
- mem_rdata  in  LINE_W  downstream fill data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g is chosen combinationally from req_valid.
  - req_ready[g]=1 in the same cycle; that cycle is the handshake.
  - The request (we, addr, wdata) and g are registered, then → ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE:
  - mem_req_valid=1, driven from registers.
  - mem_req_ready=1 → WAIT, watchdog cleared.
- WAIT:
  - mem_resp_valid=1 → mem_rdata registered, err=0, → RESP.
  - TIMEOUT≠0 and counter reaches TIMEOUT → err=1, rdata=0, → RESP.
- RESP:
  - resp_valid[g]=1 for one cycle; resp_err and resp_rdata are held from registers.
  - RR_MODE=1: priority pointer becomes g+1, wrapping NUM_REQ-1 → 0.
  - → IDLE.
- Round-robin search starts at the pointer and scans upward with wrap. Fixed priority picks the lowest set index.
- mem_resp_valid outside WAIT is ignored: no state change, no resp_valid.
- A requester must hold valid/addr/data until req_ready. Dropping valid before grant is legal and is not counted.
- resp_rdata is meaningless for writes. Writes still wait for mem_resp_valid.

## Timing
- Reset values:
  - state IDLE, pointer 0, watchdog 0, captured registers 0.
  - req_ready, resp_valid, mem_req_valid: 0.
  - resp_err 0, resp_rdata 0, mem outputs 0.
- Reset mid-transaction aborts it: no response to the owner, and a late mem_resp_valid is ignored.
- Minimum latency with mem_req_ready tied 1 and the downstream answering in the cycle after acceptance:
  - handshake at T.
  - mem_req_valid at T+1.
  - mem_resp_valid at T+2.
  - resp_valid at T+3.
  - Next grant possible at T+4.
- The watchdog counts cycles spent in WAIT. Counter width is $clog2(TIMEOUT+1); it saturates and does not wrap.
- No combinational path from mem_* inputs to req_ready/resp_* outputs.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum arb_state_e.
  - mem_req_t struct {we, addr, wdata}, parametrised through package localparams matching codebase defaults.
  - typedef for the pointer width.
- Sub-module rr_picker (NUM_REQ, RR_MODE): inputs valid vector and pointer; outputs one-hot grant and binary index. Purely combinational.
- mem_arbiter holds the FSM, capture registers and watchdog.

## Test plan
- Single read: req_valid=3'b010, addr 0x40, downstream returns 0xA5.. after 2 cycles → req_ready=3'b010 once, mem_addr=0x40, resp_valid=3'b010 with rdata 0xA5…, resp_err=0.
- Round-robin fairness: all three valid continuously, RR_MODE=1 → grant order 0,1,2,0,1,2 across six transactions.
- Fixed priority: RR_MODE=0, channels 0 and 2 continuously valid → channel 0 always granted, channel 2 never.
- Downstream backpressure: mem_req_ready low 5 cycles → mem_req_valid held and mem_addr stable for 5 cycles; one request accepted on the 6th.
- Timeout: TIMEOUT=8, no mem_resp_valid → resp_valid to the owner 9 cycles after entering WAIT, resp_err=1, rdata=0. A later stray mem_resp_valid produces no output.
- Reset in WAIT: assert rst for 1 cycle → all outputs 0 immediately, next request is granted from pointer 0, and the old response is ignored.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the line-granular memory arbiter: FSM states, request record, pointer type.
package mem_arb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int ADDR_W_DEF  = 32;
    localparam int LINE_W_DEF  = 256;
    localparam int PTR_W_DEF   = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [LINE_W_DEF-1:0] wdata;
    } mem_req_t;

    typedef logic [PTR_W_DEF-1:0] ptr_t;

    // A disabled watchdog still gets a 1-bit counter so no zero-width vectors appear.
    function automatic int wdog_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Purpose: pick one requester, round-robin from ptr with wrap or fixed priority (index 0 highest).
// Latency: purely combinational.
// Backpressure: none; grant is zero when no valid is set.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int RR_MODE = 1
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W:0] pos;
    logic           found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr is always below NUM_REQ, so one subtraction performs the wrap
            pos = (RR_MODE != 0) ? ({1'b0, ptr} + (PTR_W+1)'(k)) : (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NUM_REQ)) begin
                pos = pos - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && valid[pos[PTR_W-1:0]]) begin
                found                  = 1'b1;
                grant[pos[PTR_W-1:0]] = 1'b1;
                idx                    = pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: blocking arbiter giving NUM_REQ cache requesters one-at-a-time access to a line memory port.
// Latency: grant at T, mem request T+1, response to owner one cycle after mem_resp_valid, regrant T+4 minimum.
// Backpressure: holds mem_req_valid until mem_req_ready; no grants while a transaction is in flight.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic                      resp_err,
    output logic [LINE_W-1:0]         resp_rdata,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LINE_W-1:0]         mem_wdata,
    input  logic                      mem_resp_valid,
    input  logic [LINE_W-1:0]         mem_rdata
);

    localparam int               PTR_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = wdog_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    arb_state_e         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   own_idx;
    logic [NUM_REQ-1:0] own_oh;
    logic [CNT_W-1:0]   wdog;
    logic               wdog_fire;

    logic               cap_we;
    logic [ADDR_W-1:0]  cap_addr;
    logic [LINE_W-1:0]  cap_wdata;
    logic               mem_req_valid_q;
    logic [NUM_REQ-1:0] resp_valid_q;
    logic               resp_err_q;
    logic [LINE_W-1:0]  resp_rdata_q;

    logic [NUM_REQ-1:0] pick_oh;
    logic [PTR_W-1:0]   pick_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .RR_MODE (RR_MODE)
    ) u_picker (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

    // Ready only depends on req_valid and registered state, never on mem_* inputs.
    assign req_ready = ((state == IDLE) && !rst) ? pick_oh : '0;
    assign wdog_fire = (TIMEOUT != 0) && (wdog == TO_VAL);

    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = cap_we;
    assign mem_addr      = cap_addr;
    assign mem_wdata     = cap_wdata;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            own_idx         <= '0;
            own_oh          <= '0;
            wdog            <= '0;
            cap_we          <= 1'b0;
            cap_addr        <= '0;
            cap_wdata       <= '0;
            mem_req_valid_q <= 1'b0;
            resp_valid_q    <= '0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        cap_we          <= req_we[pick_idx];
                        cap_addr        <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        cap_wdata       <= req_wdata[pick_idx*LINE_W +: LINE_W];
                        own_idx         <= pick_idx;
                        own_oh          <= pick_oh;
                        mem_req_valid_q <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        wdog            <= '0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    // A real response wins over a watchdog expiry in the same cycle.
                    if (mem_resp_valid) begin
                        resp_rdata_q <= mem_rdata;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= own_oh;
                        state        <= RESP;
                    end else if (wdog_fire) begin
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= own_oh;
                        state        <= RESP;
                    end else if (wdog != CNT_MAX) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    resp_valid_q <= '0;
                    if (RR_MODE != 0) begin
                        ptr <= (own_idx == LAST_IDX) ? '0 : own_idx + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench: a round-robin and a fixed-priority arbiter share every input; a rule-level model predicts grants and responses.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic         clk;
    logic         rst;
    logic [2:0]   req_valid;
    logic [2:0]   req_we;
    logic [95:0]  req_addr;
    logic [767:0] req_wdata;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [255:0] mem_rdata;

    logic [2:0]   req_ready, resp_valid;
    logic         resp_err, mem_req_valid, mem_we;
    logic [255:0] resp_rdata, mem_wdata;
    logic [31:0]  mem_addr;

    logic [2:0]   fp_req_ready, fp_resp_valid;
    logic         fp_resp_err, fp_mem_req_valid, fp_mem_we;
    logic [255:0] fp_resp_rdata, fp_mem_wdata;
    logic [31:0]  fp_mem_addr;

    int total = 0;
    int bad   = 0;
    int ptr;
    int ga, gb;
    mem_req_t ch [3];

    mem_arbiter #(.NUM_REQ(3), .ADDR_W(32), .LINE_W(256), .RR_MODE(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.NUM_REQ(3), .ADDR_W(32), .LINE_W(256), .RR_MODE(0), .TIMEOUT(8)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(fp_resp_valid), .resp_err(fp_resp_err),
        .resp_rdata(fp_resp_rdata), .mem_req_valid(fp_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not reach its summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference arbitration rule: first valid index at or after p, with wrap; fixed priority scans from 0.
    function automatic int pick(input logic [2:0] v, input int p, input bit rr);
        int j;
        for (int k = 0; k < 3; k++) begin
            j = rr ? (p + k) % 3 : k;
            if (v[j]) return j;
        end
        return 0;
    endfunction

    task automatic set_req(input int i, input logic we, input logic [31:0] addr, input logic [255:0] wd);
        ch[i].we    = we;
        ch[i].addr  = addr;
        ch[i].wdata = wd;
        req_we[i]              = we;
        req_addr[i*32 +: 32]   = addr;
        req_wdata[i*256 +: 256] = wd;
    endtask

    task automatic new_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFC0, rand_line());
    endtask

    // One full transaction; starts on the first IDLE cycle and returns on the response cycle.
    task automatic txn(input logic [2:0] vld, input int rdy_dly, input int rsp_dly, input bit tmo,
                       input logic [255:0] rd, output int ga_o, output int gb_o);
        int         a, b, nwait;
        logic [2:0] oa, ob;
        mem_req_t   ra, rb;
        @(negedge clk);
        req_valid      = vld;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        chk("idle_resp_valid", resp_valid, 3'b000);
        a = pick(vld, ptr, 1'b1);
        b = pick(vld, 0, 1'b0);
        oa = 3'b000; oa[a] = 1'b1;
        ob = 3'b000; ob[b] = 1'b1;
        chk("req_ready", req_ready, oa);
        chk("fp_req_ready", fp_req_ready, ob);
        ra = ch[a];
        rb = ch[b];
        @(negedge clk);
        new_req(a);
        #1;
        chk("ready_after_grant", req_ready, 3'b000);
        chk("mem_we", mem_we, ra.we);
        chk("mem_addr", mem_addr, ra.addr);
        chk("mem_wdata", mem_wdata, ra.wdata);
        chk("fp_mem_addr", fp_mem_addr, rb.addr);
        chk("fp_mem_we", fp_mem_we, rb.we);
        for (int k = 0; k < rdy_dly; k++) begin
            chk("mem_req_valid_held", mem_req_valid, 1'b1);
            chk("mem_addr_stable", mem_addr, ra.addr);
            @(negedge clk); #1;
        end
        mem_req_ready = 1'b1;
        chk("mem_req_valid", mem_req_valid, 1'b1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        chk("mem_req_valid_drop", mem_req_valid, 1'b0);
        nwait = tmo ? 9 : rsp_dly;
        for (int k = 0; k < nwait; k++) begin
            chk("wait_resp_valid", resp_valid, 3'b000);
            @(negedge clk); #1;
        end
        if (!tmo) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = rd;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_rdata      = rand_line();
            #1;
        end
        chk("resp_valid", resp_valid, oa);
        chk("fp_resp_valid", fp_resp_valid, ob);
        chk("resp_err", resp_err, tmo);
        chk("fp_resp_err", fp_resp_err, tmo);
        if (tmo) chk("resp_rdata_timeout", resp_rdata, 256'd0);
        else if (!ra.we) chk("resp_rdata", resp_rdata, rd);
        if (!tmo && !rb.we) chk("fp_resp_rdata", fp_resp_rdata, rd);
        ptr  = (a + 1) % 3;
        ga_o = a;
        gb_o = b;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 3'b000; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        ptr = 0;
        for (int i = 0; i < 3; i++) new_req(i);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 3'b000);
        chk("rst_resp_valid", resp_valid, 3'b000);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 256'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wdata", mem_wdata, 256'd0);
        rst = 1'b0;

        // All three continuously valid: strict rotation on the round-robin instance.
        for (int k = 0; k < 6; k++) begin
            txn(3'b111, 0, 0, 1'b0, rand_line(), ga, gb);
            chk("rr_order", ga, k % 3);
            chk("fp_order", gb, 0);
        end

        // Channels 0 and 2: fixed priority never serves channel 2.
        for (int k = 0; k < 3; k++) begin
            txn(3'b101, 0, 1, 1'b0, rand_line(), ga, gb);
            chk("fp_101_winner", gb, 0);
        end

        // Single line fill on channel 1.
        set_req(1, 1'b0, 32'h0000_0040, rand_line());
        txn(3'b010, 0, 1, 1'b0, {8{32'hA5A5_A5A5}}, ga, gb);
        chk("single_read_owner", ga, 1);

        // Downstream holds mem_req_ready low for five cycles.
        txn(3'b001, 5, 2, 1'b0, rand_line(), ga, gb);

        for (int k = 0; k < 20; k++) begin
            txn(3'($urandom_range(1, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                1'b0, rand_line(), ga, gb);
        end

        // Watchdog expiry, then a stray late response.
        txn(3'b100, 0, 0, 1'b1, 256'd0, ga, gb);
        @(negedge clk);
        req_valid      = 3'b000;
        mem_resp_valid = 1'b1;
        mem_rdata      = rand_line();
        #1;
        chk("stray_req_ready", req_ready, 3'b000);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("stray_resp_valid", resp_valid, 3'b000);
        chk("stray_fp_resp_valid", fp_resp_valid, 3'b000);
        chk("stray_mem_req_valid", mem_req_valid, 1'b0);
        @(negedge clk); #1;
        chk("stray_resp_valid_late", resp_valid, 3'b000);

        // Leave the pointer at 2, then abort a transaction in WAIT with reset.
        txn(3'b010, 0, 0, 1'b0, rand_line(), ga, gb);
        @(negedge clk);
        req_valid = 3'b100;
        #1;
        chk("abort_grant", req_ready, 3'b100);
        @(negedge clk);
        req_valid     = 3'b000;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        chk("abort_in_wait", mem_req_valid, 1'b0);
        req_valid = 3'b110;
        rst       = 1'b1;
        #1;
        chk("arst_req_ready", req_ready, 3'b000);
        chk("arst_fp_req_ready", fp_req_ready, 3'b000);
        chk("arst_resp_valid", resp_valid, 3'b000);
        chk("arst_mem_req_valid", mem_req_valid, 1'b0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk("arst_mem_we", mem_we, 1'b0);
        chk("arst_mem_wdata", mem_wdata, 256'd0);
        chk("arst_resp_err", resp_err, 1'b0);
        chk("arst_resp_rdata", resp_rdata, 256'd0);
        @(negedge clk);
        rst            = 1'b0;
        req_valid      = 3'b000;
        mem_resp_valid = 1'b1;
        mem_rdata      = rand_line();
        ptr            = 0;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("late_resp_ignored", resp_valid, 3'b000);
        chk("late_fp_resp_ignored", fp_resp_valid, 3'b000);
        chk("late_mem_req_valid", mem_req_valid, 1'b0);
        @(negedge clk); #1;
        chk("late_resp_ignored_2", resp_valid, 3'b000);
        txn(3'b110, 0, 0, 1'b0, rand_line(), ga, gb);
        chk("post_reset_grant", ga, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
